// File: rtl/dma_pkg.sv
// Shared constants for the AHB-lite DMA initiator: FSM state codes,
// AHB transfer/size encodings and the fixed protection attribute.
package dma_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_RD_A = 3'd1;
  localparam state_t S_RD_D = 3'd2;
  localparam state_t S_WR_A = 3'd3;
  localparam state_t S_WR_D = 3'd4;
  localparam state_t S_DONE = 3'd5;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [3:0] HPROT_DATA = 4'b0011;

  // Size code 3 behaves exactly like a word beat.
  function automatic logic [1:0] norm_size(input logic [1:0] s);
    return (s == 2'd3) ? SZ_WORD : s;
  endfunction

endpackage

// File: rtl/dma_lane_align.sv
// Picks the beat out of the read bus at the source lane and replicates
// it across every write lane, so the destination lane is always covered.
module dma_lane_align
  import dma_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  output logic [31:0] wdata
);

  logic [7:0]  beat_b;
  logic [15:0] beat_h;

  always_comb begin
    beat_b = rdata[{addr_lo, 3'b000} +: 8];
    beat_h = rdata[{addr_lo[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: wdata = {4{beat_b}};
      SZ_HALF: wdata = {2{beat_h}};
      default: wdata = rdata;
    endcase
  end

endmodule

// File: rtl/ahb_dma_master.sv
// AHB-lite DMA initiator: single read/write pairs per beat, DONE pulse at end.
// Define DMA_ERR_RESP_EN to abort on an ERROR response and flag DMAerr.
module ahb_dma_master
  import dma_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              DMAstart,
  input  logic [ADDR_W-1:0] DMAsrc,
  input  logic [ADDR_W-1:0] DMAdst,
  input  logic [1:0]        DMAsize,
  input  logic [ADDR_W-1:0] DMAlen,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic              HMASTLOCK,
  output logic              HWRITE,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic [1:0]        HRESP,
  output logic              DMAbusy,
  output logic              DMAdone,
  output logic              DMAerr
);

  state_t            state_q, state_d;
  logic              start_q;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [1:0]        size_q, size_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rd_beat;
  logic [ADDR_W-1:0] step;
  logic              start_acc;
  logic              bus_err;
  logic              unused_hresp;

  dma_lane_align u_align (
    .rdata   (HRDATA),
    .addr_lo (src_q[1:0]),
    .size    (size_q),
    .wdata   (rd_beat)
  );

  assign start_acc = DMAstart & ~start_q
                   & (state_q == S_IDLE);
  assign step = ADDR_W'(1) << size_q;
  assign unused_hresp = ^HRESP;

`ifdef DMA_ERR_RESP_EN
  assign bus_err = HREADY & HRESP[0];
`else
  assign bus_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    size_d  = size_q;
    buf_d   = buf_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (start_acc) begin
        src_d   = DMAsrc;
        dst_d   = DMAdst;
        size_d  = norm_size(DMAsize);
        len_d   = DMAlen;
        err_d   = 1'b0;
        state_d = (DMAlen == '0) ? S_DONE : S_RD_A;
      end
      S_RD_A: if (HREADY) state_d = S_RD_D;
      S_RD_D: if (bus_err) begin
        err_d   = 1'b1;
        state_d = S_DONE;
      end else if (HREADY) begin
        buf_d   = rd_beat;
        state_d = S_WR_A;
      end
      S_WR_A: if (HREADY) state_d = S_WR_D;
      S_WR_D: if (bus_err) begin
        err_d   = 1'b1;
        state_d = S_DONE;
      end else if (HREADY) begin
        src_d   = src_q + step;
        dst_d   = dst_q + step;
        len_d   = len_q - ADDR_W'(1);
        state_d = (len_q == ADDR_W'(1)) ? S_DONE : S_RD_A;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      size_q  <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= DMAstart;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      size_q  <= size_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
    end
  end

  // Address phases only; data phases present IDLE so no pipelining occurs.
  assign HTRANS = (state_q == S_RD_A || state_q == S_WR_A)
                ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR = (state_q == S_RD_A) ? src_q
               : (state_q == S_WR_A) ? dst_q : '0;
  assign HWRITE    = (state_q == S_WR_A);
  assign HWDATA    = buf_q;
  assign HSIZE     = {1'b0, size_q};
  assign HBURST    = 3'b000;
  assign HPROT     = HPROT_DATA;
  assign HMASTLOCK = 1'b0;
  assign DMAbusy   = (state_q != S_IDLE) && (state_q != S_DONE);
  assign DMAdone   = (state_q == S_DONE);
  assign DMAerr    = err_q;

endmodule

// File: tb/tb_ahb_dma_master.sv
// Scoreboard bench for ahb_dma_master: reactive AHB slave/monitor plus
// a beat-level reference model of the copy.
module tb_ahb_dma_master;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        DMAstart;
  logic [31:0] DMAsrc, DMAdst, DMAlen;
  logic [1:0]  DMAsize;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK, HWRITE;
  logic [31:0] HWDATA, HRDATA;
  logic        HREADY;
  logic [1:0]  HRESP;
  logic        DMAbusy, DMAdone, DMAerr;

  ahb_dma_master dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .DMAstart(DMAstart), .DMAsrc(DMAsrc),
    .DMAdst(DMAdst), .DMAsize(DMAsize),
    .DMAlen(DMAlen), .HADDR(HADDR),
    .HTRANS(HTRANS), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT),
    .HMASTLOCK(HMASTLOCK), .HWRITE(HWRITE),
    .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP),
    .DMAbusy(DMAbusy), .DMAdone(DMAdone),
    .DMAerr(DMAerr)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  bit [31:0] mem [bit [31:0]];

  int n_vec = 0;
  int n_bad = 0;

  int cfg_wait = 0;
  int cfg_err_rd = 0;
  logic [2:0] exp_hsize = 3'd0;
  int done_cnt = 0;
  int busy_cyc = 0;
  int nonseq_cnt = 0;
  int rd_cnt = 0;

  function automatic bit [31:0] mem_rd(bit [31:0] a);
    bit [31:0] w;
    w = a & ~32'h3;
    if (mem.exists(w)) return mem[w];
    return (w * 32'h9E3779B1) ^ 32'h5BD1E995;
  endfunction

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // Reactive slave and bus monitor: acts on the falling edge.
  bit        pend, pend_wr, pend_done;
  bit        taken, tk_wr, wd_valid;
  bit [31:0] pend_addr, tk_addr, wd0;
  int        wait_left;

  initial begin
    HREADY = 1'b1;
    HRESP  = 2'b00;
    HRDATA = 32'h0;
    pend = 0; pend_done = 0; taken = 0;
    forever begin
      @(negedge HCLK);
      if (HRESET) begin
        pend = 0; pend_done = 0; taken = 0;
        HREADY = 1'b1;
        HRESP  = 2'b00;
      end else begin
        if (DMAdone) done_cnt++;
        if (DMAbusy) busy_cyc++;
        if (pend_done) begin
          pend = 0;
          pend_done = 0;
        end
        if (taken) begin
          pend = 1;
          pend_addr = tk_addr;
          pend_wr = tk_wr;
          wait_left = cfg_wait;
          wd_valid = 0;
          taken = 0;
        end
        HRESP = 2'b00;
        if (pend) begin
          HREADY = (wait_left == 0);
          if (wait_left > 0) wait_left--;
          if (pend_wr) begin
            if (wd_valid) chk("hwdata_hold", HWDATA, wd0);
            else begin
              wd0 = HWDATA;
              wd_valid = 1;
            end
            if (HREADY) begin
              if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL extra_write: addr %h data %h",
                         pend_addr, HWDATA);
              end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", pend_addr, e.addr);
                chk("wr_data", HWDATA, e.data);
              end
            end
          end else begin
            HRDATA = mem_rd(pend_addr);
            if (HREADY) begin
              rd_cnt++;
              if (rd_cnt == cfg_err_rd) HRESP = 2'b01;
            end
          end
          pend_done = HREADY;
        end else begin
          HREADY = 1'b1;
        end
        if (HTRANS == 2'b10 && HREADY) begin
          nonseq_cnt++;
          chk("hsize", {29'd0, HSIZE}, {29'd0, exp_hsize});
          taken = 1;
          tk_addr = HADDR;
          tk_wr = HWRITE;
        end
      end
    end
  end

  // One copy job: model pushes expected writes, then the DUT runs it.
  task automatic run_job(input bit [31:0] s, input bit [31:0] d,
                         input bit [1:0] sz, input bit [31:0] len,
                         input int wt, input int erd,
                         input int hold, input string tag);
    int beats, exp_busy, exp_ns, ssz, step, cyc;
    bit exp_err;
    bit [31:0] a, w, v;
    ssz = (sz == 2'd3) ? 2 : int'(sz);
    step = 1 << ssz;
    beats = int'(len);
    exp_err = 0;
`ifdef DMA_ERR_RESP_EN
    if (erd > 0 && erd <= int'(len)) begin
      beats = erd - 1;
      exp_err = 1;
    end
`endif
    for (int i = 0; i < beats; i++) begin
      a = s + 32'(i * step);
      w = mem_rd(a);
      if (ssz == 0)
        v = ((w >> (8 * (a % 4))) & 32'hFF) * 32'h01010101;
      else if (ssz == 1)
        v = ((w >> (16 * ((a / 2) % 2))) & 32'hFFFF)
            * 32'h00010001;
      else
        v = w;
      exp_q.push_back('{addr: d + 32'(i * step), data: v});
    end
    if (exp_err) begin
      exp_ns = 2 * beats + 1;
      exp_busy = (4 + 2 * wt) * beats + 2 + wt;
    end else begin
      exp_ns = 2 * int'(len);
      exp_busy = (4 + 2 * wt) * int'(len);
    end
    cfg_wait = wt;
    cfg_err_rd = erd;
    exp_hsize = 3'(ssz);
    rd_cnt = 0;
    done_cnt = 0;
    busy_cyc = 0;
    nonseq_cnt = 0;
    @(negedge HCLK);
    DMAsrc = s;
    DMAdst = d;
    DMAsize = sz;
    DMAlen = len;
    DMAstart = 1'b1;
    @(negedge HCLK);
    chk({tag, "_err_clr"}, {31'd0, DMAerr}, 32'd0);
    DMAsrc = $urandom;
    DMAdst = $urandom;
    DMAsize = 2'($urandom);
    DMAlen = $urandom;
    cyc = 0;
    while (done_cnt == 0 && cyc < 2000) begin
      @(negedge HCLK);
      cyc++;
    end
    if (done_cnt == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s_timeout: no DMAdone in %0d cycles",
               tag, cyc);
    end
    repeat (hold) @(negedge HCLK);
    DMAstart = 1'b0;
    repeat (4) @(negedge HCLK);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_busy_cyc"}, busy_cyc, exp_busy);
    chk({tag, "_nonseq"}, nonseq_cnt, exp_ns);
    chk({tag, "_busy_end"}, {31'd0, DMAbusy}, 32'd0);
    chk({tag, "_err"}, {31'd0, DMAerr}, {31'd0, exp_err});
    chk({tag, "_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_htrans"}, {30'd0, HTRANS}, 32'd0);
    chk({tag, "_haddr"}, HADDR, 32'd0);
    chk({tag, "_hwrite"}, {31'd0, HWRITE}, 32'd0);
    chk({tag, "_hwdata"}, HWDATA, 32'd0);
    chk({tag, "_busy"}, {31'd0, DMAbusy}, 32'd0);
    chk({tag, "_done"}, {31'd0, DMAdone}, 32'd0);
    chk({tag, "_err"}, {31'd0, DMAerr}, 32'd0);
  endtask

  initial begin
    int cyc;
    HRESET = 1'b1;
    DMAstart = 1'b0;
    DMAsrc = '0;
    DMAdst = '0;
    DMAsize = '0;
    DMAlen = '0;
    mem[32'h3000_0000] = 32'h005A_A500;
    #2;
    chk_reset_vals("rst");
    chk("rst_hburst", {29'd0, HBURST}, 32'd0);
    chk("rst_hprot", {28'd0, HPROT}, 32'h3);
    chk("rst_hlock", {31'd0, HMASTLOCK}, 32'd0);
    repeat (2) @(negedge HCLK);
    HRESET = 1'b0;

    run_job(32'h2000_0000, 32'h2000_0100, 2'd2, 3, 0, 0, 0, "word");
    run_job(32'h3000_0001, 32'h4000_0003, 2'd0, 2, 0, 0, 0, "byte");
    run_job(32'h2000_0040, 32'h2000_0200, 2'd2, 1, 2, 0, 0, "wait");
    run_job(32'h2000_0000, 32'h2000_0300, 2'd2, 0, 0, 0, 10, "zero");
    run_job(32'h1000_0002, 32'h2000_0402, 2'd1, 3, 1, 0, 0, "half");
    run_job(32'hFFFF_FFFE, 32'h2000_0500, 2'd1, 3, 0, 0, 0, "wrap");
    run_job(32'h1000_0010, 32'h2000_0600, 2'd3, 2, 0, 0, 0, "sz3");
    run_job(32'h1000_0100, 32'h2000_0700, 2'd2, 4, 0, 2, 0, "eresp");
    run_job(32'h1000_0200, 32'h2000_0800, 2'd2, 2, 0, 0, 0, "after");

    for (int j = 0; j < 8; j++) begin
      run_job(32'h1000_0000 | 32'($urandom_range(0, 4095)),
              32'h2000_0000 | 32'($urandom_range(0, 4095)),
              2'($urandom_range(0, 3)),
              32'($urandom_range(1, 6)),
              $urandom_range(0, 2), 0,
              $urandom_range(0, 3), "rand");
    end

    // Abort a transfer while its write data phase is stalled.
    cfg_wait = 3;
    cfg_err_rd = 0;
    exp_hsize = 3'd2;
    @(negedge HCLK);
    DMAsrc = 32'h1000_0300;
    DMAdst = 32'h2000_0900;
    DMAsize = 2'd2;
    DMAlen = 2;
    DMAstart = 1'b1;
    cyc = 0;
    while (HWRITE !== 1'b1 && cyc < 200) begin
      @(negedge HCLK);
      cyc++;
    end
    chk("mid_reach_wr", {31'd0, HWRITE}, 32'd1);
    @(negedge HCLK);
    #1;
    HRESET = 1'b1;
    DMAstart = 1'b0;
    #1;
    chk_reset_vals("mid");
    exp_q.delete();
    repeat (2) @(negedge HCLK);
    HRESET = 1'b0;
    run_job(32'h1000_0400, 32'h2000_0A00, 2'd2, 2, 0, 0, 0, "post");

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
